// File: rtl/sdram_if_pkg.sv
// rtl/sdram_if_pkg.sv - shared encodings, FSM states and alignment helper for the SDRAM initiator
package sdram_if_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    STORE,
    RESP
  } state_t;

  // Size 3 is reported as misaligned so that every error takes the same path.
  function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: return 1'b1;
      SZ_HALF: return ~addr_lo[0];
      SZ_WORD: return (addr_lo == 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/sdram_lane_merge.sv
// rtl/sdram_lane_merge.sv - big-endian byte/half lane insert and extract for one 32-bit word
module sdram_lane_merge
  import sdram_if_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic [31:0] wdata,
  input  logic        sign_ext,
  output logic [31:0] merged,
  output logic [31:0] load_val
);

  logic [4:0]  shamt;
  logic [31:0] mask;
  logic [31:0] lane;

  always_comb begin
    shamt = 5'd0;
    mask  = 32'hFFFF_FFFF;
    case (size)
      // Big-endian: offset 0 is the top lane, so the shift is (3-k)*8 bits.
      SZ_BYTE: begin
        shamt = {~offset, 3'b000};
        mask  = 32'h0000_00FF;
      end
      SZ_HALF: begin
        shamt = {~offset[1], 4'b0000};
        mask  = 32'h0000_FFFF;
      end
      default: ;
    endcase

    merged   = (word & ~(mask << shamt)) | ((wdata & mask) << shamt);
    lane     = (word >> shamt) & mask;
    load_val = lane;
    if (sign_ext) begin
      case (size)
        SZ_BYTE: load_val = {{24{lane[7]}}, lane[7:0]};
        SZ_HALF: load_val = {{16{lane[15]}}, lane[15:0]};
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sdram_initiator.sv
// rtl/sdram_initiator.sv - core load/store port to level request/ack memory initiator
module sdram_initiator
  import sdram_if_pkg::*;
#(
  parameter int AWIDTH = 25
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [AWIDTH-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  output logic              rsp_err,
  output logic [31:0]       rsp_rdata,
  output logic              wr_req,
  output logic              rd_req,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              wr_ack,
  input  logic              rd_ack,
  input  logic [31:0]       rd_data
);

  state_t      state, state_next;
  logic [1:0]  lat_off;
  logic [1:0]  lat_size;
  logic        lat_signed;
  logic [31:0] lat_wdata;
  logic [31:0] merged;
  logic [31:0] load_val;
  logic        accept;
  logic        rd_done;
  logic        wr_done;

  assign accept  = (state == IDLE) && req_valid;
  assign rd_done = rd_ack && rd_req;
  assign wr_done = wr_ack && wr_req;

  sdram_lane_merge u_merge (
    .word     (rd_data),
    .offset   (lat_off),
    .size     (lat_size),
    .wdata    (lat_wdata),
    .sign_ext (lat_signed),
    .merged   (merged),
    .load_val (load_val)
  );

  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (!is_aligned(req_size, req_addr[1:0])) state_next = RESP;
          else if (!req_we)                         state_next = LOAD;
          else if (req_size == SZ_WORD)             state_next = STORE;
          else                                      state_next = RMW_RD;
        end
      end
      LOAD:    if (rd_done) state_next = RESP;
      RMW_RD:  if (rd_done) state_next = STORE;
      STORE:   if (wr_done) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // wr_req is held off for the first STORE cycle after RMW_RD so rd_req is seen low first.
  always_ff @(posedge CLK) begin
    if (RST) begin
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_rdata  <= 32'd0;
      wr_req     <= 1'b0;
      rd_req     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      lat_off    <= 2'd0;
      lat_size   <= SZ_BYTE;
      lat_signed <= 1'b0;
      lat_wdata  <= 32'd0;
    end else begin
      req_ready <= (state_next == IDLE);
      rsp_valid <= (state_next == RESP);
      rd_req    <= (state_next == LOAD) || (state_next == RMW_RD);
      wr_req    <= (state_next == STORE) && (state != RMW_RD);
      if (accept) begin
        lat_off    <= req_addr[1:0];
        lat_size   <= req_size;
        lat_signed <= req_signed;
        lat_wdata  <= req_wdata;
        mem_addr   <= {req_addr[AWIDTH-1:2], 2'b00};
        rsp_err    <= !is_aligned(req_size, req_addr[1:0]);
        rsp_rdata  <= 32'd0;
        if (req_we && req_size == SZ_WORD) mem_wdata <= req_wdata;
      end
      if (state == LOAD && rd_done)   rsp_rdata <= load_val;
      if (state == RMW_RD && rd_done) mem_wdata <= merged;
    end
  end

endmodule

// File: tb/tb_sdram_initiator.sv
// tb/tb_sdram_initiator.sv - scoreboard bench with a delayed-ack memory responder
module tb_sdram_initiator;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [24:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [31:0] rsp_rdata;
  logic        wr_req;
  logic        rd_req;
  logic [24:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        wr_ack = 1'b0;
  logic        rd_ack = 1'b0;
  logic [31:0] rd_data = '0;

  int checks = 0;
  int failures = 0;
  logic [32:0] sb_q[$];
  logic [31:0] mem[int];
  int rd_rises = 0;
  int wr_rises = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;
  logic hold_wr = 1'b0;
  int rd_before;
  int wr_before;

  sdram_initiator #(.AWIDTH(25)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .wr_req(wr_req), .rd_req(rd_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .wr_ack(wr_ack),
    .rd_ack(rd_ack), .rd_data(rd_data)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory responder: random ack delay, checks each request drops right after its ack.
  initial begin
    forever begin
      @(negedge CLK);
      if (RST) begin
        rd_ack = 1'b0; wr_ack = 1'b0; prev_rd = 1'b0; prev_wr = 1'b0;
        continue;
      end
      if (rd_req && !prev_rd) begin rd_rises++; rd_cnt = $urandom_range(0, 2); end
      if (wr_req && !prev_wr) begin
        wr_rises++; wr_cnt = $urandom_range(0, 2);
        check("rd_low_before_wr", 32'(prev_rd), 32'd0);
      end
      if (rd_req || wr_req) check("req_exclusive", 32'(rd_req & wr_req), 32'd0);
      if (rd_ack) begin
        rd_ack = 1'b0;
        check("rd_drop_after_ack", 32'(rd_req), 32'd0);
      end else if (rd_req) begin
        if (rd_cnt == 0) begin
          rd_data = mem.exists(int'(mem_addr)) ? mem[int'(mem_addr)] : 32'd0;
          rd_ack = 1'b1;
        end else rd_cnt--;
      end
      if (wr_ack) begin
        wr_ack = 1'b0;
        check("wr_drop_after_ack", 32'(wr_req), 32'd0);
      end else if (wr_req && !hold_wr) begin
        if (wr_cnt == 0) begin
          mem[int'(mem_addr)] = mem_wdata;
          wr_ack = 1'b1;
        end else wr_cnt--;
      end
      prev_rd = rd_req;
      prev_wr = wr_req;
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (rsp_valid === 1'b1) begin
        if (sb_q.size() == 0) check("unexpected_rsp", 32'(rsp_valid), 32'd0);
        else begin
          logic [32:0] e;
          e = sb_q.pop_front();
          check("rsp_err", 32'(rsp_err), 32'(e[32]));
          check("rsp_rdata", rsp_rdata, e[31:0]);
        end
      end
    end
  end

  task automatic send(input logic we, input logic [1:0] sz, input logic sg,
                      input logic [24:0] a, input logic [31:0] wd,
                      input logic e, input logic [31:0] rd);
    int n;
    n = 0;
    @(negedge CLK);
    while (req_ready !== 1'b1 && n < 40) begin @(negedge CLK); n++; end
    if (n >= 40) check("ready_timeout", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg;
    req_addr = a; req_wdata = wd;
    sb_q.push_back({e, rd});
    @(negedge CLK);
    req_valid = 1'b0;
    check("ready_drop", 32'(req_ready), 32'd0);
    if (e) check("err_one_cycle", 32'(rsp_valid), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < 60) begin @(negedge CLK); #1; n++; end
    if (sb_q.size() != 0) begin
      check({tag, "_timeout"}, 32'(sb_q.size()), 32'd0);
      sb_q.delete();
    end
  endtask

  initial begin
    int n;
    mem[32'h100] = 32'h1122_3344;
    mem[32'h200] = 32'h0000_0000;
    mem[32'h300] = 32'h5A5A_5A5A;
    repeat (3) @(negedge CLK);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_wr_req", 32'(wr_req), 32'd0);
    check("rst_rd_req", 32'(rd_req), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    RST = 1'b0;

    send(1'b0, 2'd2, 1'b0, 25'h100, 32'd0, 1'b0, 32'h1122_3344);
    wait_done("word_load");

    mem[32'h100] = 32'h1122_33F4;
    send(1'b0, 2'd0, 1'b1, 25'h103, 32'd0, 1'b0, 32'hFFFF_FFF4);
    wait_done("byte_load_s");
    send(1'b0, 2'd0, 1'b0, 25'h103, 32'd0, 1'b0, 32'h0000_00F4);
    wait_done("byte_load_u");

    mem[32'h100] = 32'hAABB_CCDD;
    rd_before = rd_rises; wr_before = wr_rises;
    send(1'b1, 2'd1, 1'b0, 25'h102, 32'h0000_BEEF, 1'b0, 32'd0);
    wait_done("half_store");
    check("half_store_mem", mem[32'h100], 32'hAABB_BEEF);
    check("half_store_rds", 32'(rd_rises - rd_before), 32'd1);
    check("half_store_wrs", 32'(wr_rises - wr_before), 32'd1);

    send(1'b1, 2'd0, 1'b0, 25'h101, 32'h1234_5677, 1'b0, 32'd0);
    wait_done("byte_store");
    check("byte_store_mem", mem[32'h100], 32'hAA77_BEEF);
    send(1'b0, 2'd0, 1'b1, 25'h100, 32'd0, 1'b0, 32'hFFFF_FFAA);
    send(1'b0, 2'd1, 1'b1, 25'h100, 32'd0, 1'b0, 32'hFFFF_AA77);
    send(1'b0, 2'd1, 1'b0, 25'h102, 32'd0, 1'b0, 32'h0000_BEEF);
    wait_done("sub_loads");

    rd_before = rd_rises; wr_before = wr_rises;
    send(1'b1, 2'd2, 1'b0, 25'h101, 32'hDEAD_BEEF, 1'b1, 32'd0);
    send(1'b0, 2'd3, 1'b0, 25'h100, 32'd0, 1'b1, 32'd0);
    send(1'b0, 2'd1, 1'b1, 25'h103, 32'd0, 1'b1, 32'd0);
    wait_done("errors");
    check("err_no_rd", 32'(rd_rises - rd_before), 32'd0);
    check("err_no_wr", 32'(wr_rises - wr_before), 32'd0);
    check("err_mem_intact", mem[32'h100], 32'hAA77_BEEF);

    send(1'b1, 2'd2, 1'b0, 25'h200, 32'hCAFE_F00D, 1'b0, 32'd0);
    send(1'b0, 2'd2, 1'b0, 25'h200, 32'd0, 1'b0, 32'hCAFE_F00D);
    wait_done("back_to_back");
    check("b2b_mem", mem[32'h200], 32'hCAFE_F00D);

    hold_wr = 1'b1;
    send(1'b1, 2'd2, 1'b0, 25'h300, 32'h0BAD_0BAD, 1'b0, 32'd0);
    n = 0;
    while (wr_req !== 1'b1 && n < 20) begin @(negedge CLK); n++; end
    check("hold_wr_req_up", 32'(wr_req), 32'd1);
    repeat (2) @(negedge CLK);
    #1 RST = 1'b1;
    sb_q.delete();
    @(negedge CLK); #1;
    check("midrst_wr_req", 32'(wr_req), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    RST = 1'b0;
    hold_wr = 1'b0;
    send(1'b0, 2'd2, 1'b0, 25'h300, 32'd0, 1'b0, 32'h5A5A_5A5A);
    wait_done("post_rst_load");
    repeat (4) @(negedge CLK);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

endmodule
